// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial bus slave port and the interconnect:
// default widths, the slave port state enumeration and a small constant
// helper used to size counters.
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BURST_WIDTH  = 4;
  localparam int DEF_SPLIT_CYCLES = 16;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    WDATA  = 4'd2,
    MEMWR  = 4'd3,
    MEMRD  = 4'd4,
    RDWAIT = 4'd5,
    SPLIT  = 4'd6,
    RDATA  = 4'd7,
    DONE   = 4'd8
  } port_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shift.sv
// ---------------------------------------------------------------------------
// serial_shift
// Generic shift register used for serial-to-parallel and parallel-to-serial
// conversion. Bits enter at the MSB and move towards the LSB, so a word sent
// LSB first is complete after WIDTH shifts, and par_out[0] is the next bit to
// transmit when the register has been parallel loaded.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset, clears the register
//   load      parallel load of load_data (has priority over shift_en)
//   load_data parallel input word
//   shift_en  shift one position towards the LSB
//   ser_in    bit entering at the MSB on a shift
//   par_out   current register contents (bit 0 is the serial output)
// ---------------------------------------------------------------------------
module serial_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
    end else if (shift_en) begin
      shift_q <= {ser_in, shift_q[WIDTH-1:1]};
    end
  end

  assign par_out = shift_q;

endmodule

// File: rtl/slave_port.sv
// ---------------------------------------------------------------------------
// slave_port
// Serial bus slave port. A master shifts in an address and burst count (and
// write data for writes) one bit per master_valid cycle, LSB first. The port
// turns each beat into a single-cycle local memory access at base+beat
// (wrapping modulo 2^ADDR_WIDTH) and, for reads, shifts the returned word
// out on tx_data under master_ready flow control. A local split_req during
// a read releases the bus for SPLIT_CYCLES cycles before retrying.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   master_valid             master presents a valid serial bit
//   master_ready             master accepts the current read bit
//   rx_address, rx_data      serial address / write data, LSB first
//   rx_burst_num             serial burst count (beats = value+1), LSB first
//   write_en, read_en        transaction type, sampled at start
//   tx_data, slave_valid     serial read data and its valid
//   slave_ready              port can accept/continue a transaction
//   slave_split_en           high while a read is split
//   split_req                local request to split the current read
//   trans_done               one-cycle pulse at transaction end
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  local memory interface
// ---------------------------------------------------------------------------
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH  = DEF_BURST_WIDTH,
  parameter int SPLIT_CYCLES = DEF_SPLIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  master_valid,
  input  logic                  master_ready,
  input  logic                  rx_address,
  input  logic                  rx_data,
  input  logic                  rx_burst_num,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic                  tx_data,
  output logic                  slave_valid,
  output logic                  slave_ready,
  output logic                  slave_split_en,
  input  logic                  split_req,
  output logic                  trans_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int SPL_W = $clog2(SPLIT_CYCLES + 1);

  port_state_t state, state_nxt;

  logic                   is_write, is_write_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [BURST_WIDTH-1:0] beat_cnt, beat_nxt;
  logic [BURST_WIDTH-1:0] burst_q, burst_nxt;
  logic [SPL_W-1:0]       split_cnt, split_cnt_nxt;
  logic                   split_done, split_done_nxt;
  logic                   ready_int;

  logic                   addr_shift;
  logic                   data_shift;
  logic                   data_load;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [ADDR_WIDTH-1:0]  beat_addr;
  logic [DATA_WIDTH-1:0]  data_word;

  // Address shifter: filled once per transaction, then held as the base.
  serial_shift #(.WIDTH(ADDR_WIDTH)) u_addr_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ({ADDR_WIDTH{1'b0}}),
    .shift_en  (addr_shift),
    .ser_in    (rx_address),
    .par_out   (base_addr)
  );

  // One data shifter serves both directions: writes shift rx_data in and
  // present the full word, reads load mem_rdata and shift it out from bit 0.
  // The bits shifted in behind a read word are never used.
  serial_shift #(.WIDTH(DATA_WIDTH)) u_data_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (data_load),
    .load_data (mem_rdata),
    .shift_en  (data_shift),
    .ser_in    (rx_data),
    .par_out   (data_word)
  );

  // Truncation to ADDR_WIDTH gives the required wrap past the top address.
  assign beat_addr = base_addr + ADDR_WIDTH'(beat_cnt);

  // Gating with rst keeps slave_ready low for the whole reset period even
  // though the state register already reads IDLE.
  assign slave_ready = ready_int & rst;

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      bit_cnt    <= '0;
      beat_cnt   <= '0;
      burst_q    <= '0;
      split_cnt  <= '0;
      split_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      is_write   <= is_write_nxt;
      bit_cnt    <= bit_cnt_nxt;
      beat_cnt   <= beat_nxt;
      burst_q    <= burst_nxt;
      split_cnt  <= split_cnt_nxt;
      split_done <= split_done_nxt;
    end
  end

  // Next-state and output decode. bit_cnt counts serial bits within the
  // address or data phase; the address phase starts at 1 because bit 0 is
  // taken in IDLE together with the start condition.
  always_comb begin
    state_nxt      = state;
    is_write_nxt   = is_write;
    bit_cnt_nxt    = bit_cnt;
    beat_nxt       = beat_cnt;
    burst_nxt      = burst_q;
    split_cnt_nxt  = split_cnt;
    split_done_nxt = split_done;
    addr_shift     = 1'b0;
    data_shift     = 1'b0;
    data_load      = 1'b0;
    ready_int      = 1'b1;
    slave_valid    = 1'b0;
    tx_data        = 1'b0;
    slave_split_en = 1'b0;
    trans_done     = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    unique case (state)
      IDLE: begin
        if (master_valid && (write_en ^ read_en)) begin
          is_write_nxt   = write_en;
          addr_shift     = 1'b1;
          burst_nxt      = {rx_burst_num, burst_q[BURST_WIDTH-1:1]};
          bit_cnt_nxt    = CNT_W'(1);
          beat_nxt       = '0;
          split_done_nxt = 1'b0;
          state_nxt      = ADDR;
        end
      end

      ADDR: begin
        if (master_valid) begin
          addr_shift = 1'b1;
          if (bit_cnt < CNT_W'(BURST_WIDTH)) begin
            burst_nxt = {rx_burst_num, burst_q[BURST_WIDTH-1:1]};
          end
          if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = is_write ? WDATA : MEMRD;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      WDATA: begin
        if (master_valid) begin
          data_shift = 1'b1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = MEMWR;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      MEMWR: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = data_word;
        if (beat_cnt == burst_q) begin
          state_nxt = DONE;
        end else begin
          beat_nxt  = beat_cnt + 1'b1;
          state_nxt = WDATA;
        end
      end

      MEMRD: begin
        // A split granted once per beat; the retry after SPLIT ignores split_req.
        if (split_req && !split_done) begin
          split_cnt_nxt = '0;
          state_nxt     = SPLIT;
        end else begin
          mem_re         = 1'b1;
          mem_addr       = beat_addr;
          split_done_nxt = 1'b0;
          state_nxt      = RDWAIT;
        end
      end

      SPLIT: begin
        ready_int      = 1'b0;
        slave_split_en = 1'b1;
        if (split_cnt == SPL_W'(SPLIT_CYCLES - 1)) begin
          split_done_nxt = 1'b1;
          state_nxt      = MEMRD;
        end else begin
          split_cnt_nxt = split_cnt + 1'b1;
        end
      end

      RDWAIT: begin
        data_load   = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = RDATA;
      end

      RDATA: begin
        slave_valid = 1'b1;
        tx_data     = data_word[0];
        if (master_ready) begin
          data_shift = 1'b1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_nxt = '0;
            if (beat_cnt == burst_q) begin
              state_nxt = DONE;
            end else begin
              beat_nxt  = beat_cnt + 1'b1;
              state_nxt = MEMRD;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      DONE: begin
        ready_int  = 1'b0;
        trans_done = 1'b1;
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
